// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 set-2 key decoder.
package ps2_pkg;

  // Set-2 prefix and special scan codes.
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_PAUSE  = 8'hE1;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  // Bytes the keyboard sends on buffer overrun / internal error.
  localparam logic [7:0] SC_ERR_LO = 8'h00;
  localparam logic [7:0] SC_ERR_HI = 8'hFF;

  // Receiver handshake: sample, pop strobe, settle gap.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAck  = 2'd1,
    StGap  = 2'd2
  } hs_state_e;

  // Identity of a physical key: extended flag plus scan code.
  typedef struct packed {
    logic       ext;
    logic [7:0] code;
  } key_id_t;

endpackage

// File: rtl/scancode_to_ascii.sv
// Combinational set-2 scan code to ASCII lookup for letters, digits, space
// and enter. Unmapped codes return 8'h00.
module scancode_to_ascii (
  input  logic [7:0] code,
  input  logic       shift,
  output logic [7:0] ascii
);

  logic [7:0] letter;
  logic [7:0] other;

  // Lower-case letter table; zero when the code is not a letter.
  always_comb begin
    letter = 8'h00;
    case (code)
      8'h1C:   letter = 8'h61; // a
      8'h32:   letter = 8'h62; // b
      8'h21:   letter = 8'h63; // c
      8'h23:   letter = 8'h64; // d
      8'h24:   letter = 8'h65; // e
      8'h2B:   letter = 8'h66; // f
      8'h34:   letter = 8'h67; // g
      8'h33:   letter = 8'h68; // h
      8'h43:   letter = 8'h69; // i
      8'h3B:   letter = 8'h6A; // j
      8'h42:   letter = 8'h6B; // k
      8'h4B:   letter = 8'h6C; // l
      8'h3A:   letter = 8'h6D; // m
      8'h31:   letter = 8'h6E; // n
      8'h44:   letter = 8'h6F; // o
      8'h4D:   letter = 8'h70; // p
      8'h15:   letter = 8'h71; // q
      8'h2D:   letter = 8'h72; // r
      8'h1B:   letter = 8'h73; // s
      8'h2C:   letter = 8'h74; // t
      8'h3C:   letter = 8'h75; // u
      8'h2A:   letter = 8'h76; // v
      8'h1D:   letter = 8'h77; // w
      8'h22:   letter = 8'h78; // x
      8'h35:   letter = 8'h79; // y
      8'h1A:   letter = 8'h7A; // z
      default: letter = 8'h00;
    endcase
  end

  // Digits, space and enter; these ignore shift.
  always_comb begin
    other = 8'h00;
    case (code)
      8'h45:   other = 8'h30; // 0
      8'h16:   other = 8'h31; // 1
      8'h1E:   other = 8'h32; // 2
      8'h26:   other = 8'h33; // 3
      8'h25:   other = 8'h34; // 4
      8'h2E:   other = 8'h35; // 5
      8'h36:   other = 8'h36; // 6
      8'h3D:   other = 8'h37; // 7
      8'h3E:   other = 8'h38; // 8
      8'h46:   other = 8'h39; // 9
      8'h29:   other = 8'h20; // space
      8'h5A:   other = 8'h0D; // enter
      default: other = 8'h00;
    endcase
  end

  // Letter and non-letter code sets are disjoint, so a plain merge suffices.
  always_comb begin
    ascii = other;
    if (letter != 8'h00) begin
      ascii = shift ? (letter - 8'h20) : letter;
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 key decoder: pops bytes from the receiver FIFO, folds E0/F0/E1
// prefixes into single key events and tracks shift, held key and press count.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned PAUSE_LEN = 7,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [7:0]       data,
  input  logic             ready,
  input  logic             overflow,
  output logic             nextdata_n,
  output logic             key_valid,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_release,
  output logic             key_repeat,
  output logic [7:0]       key_ascii,
  output logic             shift,
  output logic [CNT_W-1:0] press_count,
  output logic             err_overflow
);

  localparam int unsigned SKIP_W = (PAUSE_LEN < 2) ? 1 : $clog2(PAUSE_LEN + 1);
  localparam logic [SKIP_W-1:0] SKIP_LOAD = SKIP_W'(PAUSE_LEN);
  localparam logic [SKIP_W-1:0] SKIP_ONE  = SKIP_W'(1);

  hs_state_e state_q;

  // A byte is consumed at the edge where IDLE sees a non-empty FIFO.
  logic take;
  assign take = (state_q == StIdle) && ready;

  // Prefix state.
  logic              ext_q, ext_d;
  logic              brk_q, brk_d;
  logic [SKIP_W-1:0] skip_q, skip_d;

  // Raw event produced by the current byte.
  logic       ev_fire;
  logic       ev_pause;
  logic       ev_ext;
  logic       ev_rel;
  logic [7:0] ev_code;

  // Key tracking state.
  key_id_t          held_q, held_d;
  logic             held_valid_q, held_valid_d;
  logic             lshift_q, lshift_d;
  logic             rshift_q, rshift_d;
  logic [CNT_W-1:0] count_d;

  key_id_t    ev_id;
  logic       held_match;
  logic       is_make;
  logic       ev_repeat;
  logic [7:0] map_ascii;
  logic [7:0] ascii_d;

  assign shift = lshift_q | rshift_q;

  // Lookup uses the shift state from before the current byte.
  scancode_to_ascii u_ascii (
    .code  (data),
    .shift (shift),
    .ascii (map_ascii)
  );

  // Prefix resolution for the byte being consumed.
  always_comb begin
    ext_d    = ext_q;
    brk_d    = brk_q;
    skip_d   = skip_q;
    ev_fire  = 1'b0;
    ev_pause = 1'b0;
    ev_ext   = 1'b0;
    ev_rel   = 1'b0;
    ev_code  = data;
    if (take) begin
      if (skip_q != '0) begin
        // Pause tail bytes are swallowed; the last one releases the event.
        skip_d = skip_q - SKIP_ONE;
        if (skip_q == SKIP_ONE) begin
          ev_fire  = 1'b1;
          ev_pause = 1'b1;
          ev_code  = SC_PAUSE;
        end
      end else begin
        case (data)
          SC_PAUSE: begin
            skip_d = SKIP_LOAD;
            ext_d  = 1'b0;
            brk_d  = 1'b0;
          end
          SC_EXT: ext_d = 1'b1;
          SC_BRK: brk_d = 1'b1;
          SC_ERR_LO, SC_ERR_HI: begin
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
          default: begin
            ev_fire = 1'b1;
            ev_ext  = ext_q;
            ev_rel  = brk_q;
            ext_d   = 1'b0;
            brk_d   = 1'b0;
          end
        endcase
      end
    end
    // Overflow means bytes were lost, so any partial sequence is meaningless.
    if (overflow) begin
      ext_d  = 1'b0;
      brk_d  = 1'b0;
      skip_d = '0;
    end
  end

  // Repeat detection, held-key, shift and press-count next state.
  always_comb begin
    ev_id        = '{ext: ev_ext, code: ev_code};
    held_match   = held_valid_q && (held_q == ev_id);
    is_make      = ev_fire && !ev_pause && !ev_rel;
    ev_repeat    = is_make && held_match;
    held_d       = held_q;
    held_valid_d = held_valid_q;
    lshift_d     = lshift_q;
    rshift_d     = rshift_q;
    count_d      = press_count;
    if (is_make && !held_match) begin
      count_d      = press_count + CNT_W'(1);
      held_d       = ev_id;
      held_valid_d = 1'b1;
    end
    if (ev_fire && !ev_pause && ev_rel && held_match) begin
      held_valid_d = 1'b0;
    end
    if (ev_fire && !ev_pause && !ev_ext) begin
      if (ev_code == SC_LSHIFT) lshift_d = !ev_rel;
      if (ev_code == SC_RSHIFT) rshift_d = !ev_rel;
    end
    ascii_d = (is_make && !ev_ext) ? map_ascii : 8'h00;
  end

  // Handshake FSM; nextdata_n is low for exactly the cycle after a sample.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q    <= StIdle;
      nextdata_n <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          nextdata_n <= 1'b1;
          if (ready) begin
            state_q    <= StAck;
            nextdata_n <= 1'b0;
          end
        end
        StAck: begin
          state_q    <= StGap;
          nextdata_n <= 1'b1;
        end
        StGap: begin
          state_q    <= StIdle;
          nextdata_n <= 1'b1;
        end
        default: begin
          state_q    <= StIdle;
          nextdata_n <= 1'b1;
        end
      endcase
    end
  end

  // Decoder state and registered event outputs; event fields hold between strobes.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      skip_q       <= '0;
      held_q       <= '0;
      held_valid_q <= 1'b0;
      lshift_q     <= 1'b0;
      rshift_q     <= 1'b0;
      press_count  <= '0;
      err_overflow <= 1'b0;
      key_valid    <= 1'b0;
      key_code     <= 8'h00;
      key_ext      <= 1'b0;
      key_release  <= 1'b0;
      key_repeat   <= 1'b0;
      key_ascii    <= 8'h00;
    end else begin
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      skip_q       <= skip_d;
      held_q       <= held_d;
      held_valid_q <= held_valid_d;
      lshift_q     <= lshift_d;
      rshift_q     <= rshift_d;
      press_count  <= count_d;
      err_overflow <= err_overflow | overflow;
      key_valid    <= ev_fire;
      if (ev_fire) begin
        key_code    <= ev_code;
        key_ext     <= ev_ext;
        key_release <= ev_rel;
        key_repeat  <= ev_repeat;
        key_ascii   <= ascii_d;
      end
    end
  end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Consumes raw scan-code bytes from the PS/2 receiver FIFO over its ready/nextdata_n handshake.
- Resolves set-2 prefixes (E0 extended, F0 break, E1 pause) into single key events carrying press/release, repeat and ASCII information.
- Tracks shift state, the currently held key and the press count.
- Sits between the PS/2 receiver and the display/application logic.

Parameters:
- PAUSE_LEN, 7, number of bytes following E1 that are discarded before the pause event is emitted.
- CNT_W, 8, width of press_count.

Ports:
- clk  input  1  system clock; sole clock domain.
- clrn  input  1  reset, synchronous, active-low.
- data  input  8  byte at the head of the receiver FIFO; valid while ready=1.
- ready  input  1  receiver FIFO non-empty.
- overflow  input  1  receiver FIFO overflow indication.
- nextdata_n  output  1  active-low pop strobe to the receiver; exactly one cycle low per consumed byte.
- key_valid  output  1  one-cycle event strobe.
- key_code  output  8  scan code of the event; held until the next event.
- key_ext  output  1  event was E0-prefixed.
- key_release  output  1  event was a break (F0-prefixed).
- key_repeat  output  1  make event equal to the currently held key (typematic).
- key_ascii  output  8  ASCII of the event; 8'h00 if unmapped, extended or break.
- shift  output  1  either shift key (12 or 59, non-extended) is currently held.
- press_count  output  CNT_W  number of non-repeat make events; wraps to 0.
- err_overflow  output  1  sticky; set when overflow=1 is sampled, cleared only by reset.

Behaviour:
- Reset is the only clock/reset scheme: one clock, clk; reset clrn is synchronous and active-low. While clrn=0 at a clk edge:
  - All outputs go to 0, except nextdata_n=1.
  - The FSM goes to IDLE.
  - ext_pending, brk_pending, skip counter, held register and shift flags are all cleared.
- Handshake FSM, three states:
  - IDLE: if ready=1, latch data, go to ACK; else stay.
  - ACK: nextdata_n=0; decode result is registered; go to GAP.
  - GAP: nextdata_n=1; go to IDLE. This gives the receiver one cycle to advance its read pointer.
  - A byte sampled in cycle N produces nextdata_n=0 and any key_valid in cycle N+1. Earliest next sample is N+3; maximum throughput is one byte per 3 cycles.
  - nextdata_n is never low in two consecutive cycles.
- Byte decode, applied in the ACK cycle:
  - Skip counter non-zero: decrement it; no event. When it reaches 0, emit an event with code E1, ext=0, release=0, repeat=0. Press_count is unaffected.
  - E1: load the skip counter with PAUSE_LEN; clear both pending flags.
  - E0: set ext_pending; no event.
  - F0: set brk_pending; no event.
  - 00 or FF: error byte; dropped; pending flags cleared; no event.
  - Any other byte: emit an event with code=byte, ext=ext_pending, release=brk_pending; then clear both pending flags.
- Event qualification:
  - Make, {ext,code} == held, held_valid=1: repeat=1; press_count unchanged.
  - Make, otherwise: repeat=0; press_count+1; held <= {ext,code}; held_valid=1.
  - Break matching held: held_valid=0. Break not matching held: held is unchanged.
  - Shift: make of 12/59 (ext=0) sets the matching shift flag; break clears it. The shift output is the OR of both flags.
- ASCII mapping:
  - Applies to non-extended make events only.
  - Letters map to 61–7A; uppercase 41–5A when shift=1, using the shift value before the current event.
  - Digits map to 30–39; space 29 maps to 20; enter 5A maps to 0D.
  - Everything else maps to 00.
- Overflow: overflow=1 sampled in any state sets err_overflow and clears the pending flags and skip counter. The handshake continues normally.
- Reset mid-sequence discards all prefix state; the next byte is decoded as a fresh, unprefixed byte.

Decomposition:
- Package ps2_pkg holds:
  - Constants SC_EXT=8'hE0, SC_BRK=8'hF0, SC_PAUSE=8'hE1, SC_LSHIFT=8'h12, SC_RSHIFT=8'h59.
  - FSM state encoding IDLE/ACK/GAP.
- One combinational sub-module, scancode_to_ascii: inputs code[7:0] and shift; output ascii[7:0]; a case lookup table. All registering is done in ps2_key_decoder.

Test Plan:
- 1C; F0 1C -> event 1 code=1C, release=0, ascii=61, press_count=1. Event 2 release=1, ascii=00, held cleared.
- 1C 1C 1C -> three key_valid pulses with repeat=0,1,1; press_count=1.
- E0 75; E0 F0 75 -> make ext=1 code=75 ascii=00; break ext=1 release=1. No events for the prefix bytes.
- 12; 1C; F0 1C; F0 12 -> ascii=41 on the 1C make. shift=1 between the 12 make and the F0 12 break, then 0. press_count=2.
- Three bytes queued with ready held high -> nextdata_n low exactly in cycles N+1, N+4, N+7. Inject overflow=1 -> err_overflow stays 1 until clrn=0.
- E0 F0, then clrn=0 for one cycle, then 75 -> event ext=0, release=0. Sequence E1 14 77 E1 F0 14 F0 77 -> exactly one event, code=E1.
